// File: rtl/pipeline_stall_controller_if.sv
// Pipeline hazard/sequencing signal bundle between the ID/EX control path and the stall controller.
// The stall_count_o signal is present only when STALL_COUNT_EN is defined.
interface pipeline_stall_controller_if #(
   parameter int R_WIDTH = 5
);
   logic [R_WIDTH-1:0] ID_rs_i;
   logic [R_WIDTH-1:0] ID_rt_i;
   logic               ID_uses_rt_i;
   logic               ID_md_use_i;
   logic               ID_branch_taken_i;
   logic [R_WIDTH-1:0] EX_rd_i;
   logic               EX_mem_read_i;
   logic               EX_md_start_i;
   logic               pc_write_o;
   logic               IF_ID_write_o;
   logic               IF_ID_flush_o;
   logic               ID_EX_flush_o;
   logic               md_busy_o;
   logic               md_done_o;
   logic               state_dbg;
`ifdef STALL_COUNT_EN
   logic [31:0]        stall_count_o;
`endif

   // Pipeline side: drives instruction info, receives enables and flushes.
   modport master (
      output ID_rs_i, ID_rt_i, ID_uses_rt_i, ID_md_use_i, ID_branch_taken_i,
      output EX_rd_i, EX_mem_read_i, EX_md_start_i,
      input  pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_flush_o,
      input  md_busy_o, md_done_o, state_dbg
`ifdef STALL_COUNT_EN
      , input stall_count_o
`endif
   );

   modport slave (
      input  ID_rs_i, ID_rt_i, ID_uses_rt_i, ID_md_use_i, ID_branch_taken_i,
      input  EX_rd_i, EX_mem_read_i, EX_md_start_i,
      output pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_flush_o,
      output md_busy_o, md_done_o, state_dbg
`ifdef STALL_COUNT_EN
      , output stall_count_o
`endif
   );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Load-use / multiply-divide hazard controller with branch flush for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining STALL_COUNT_EN.
module pipeline_stall_controller #(
   parameter int R_WIDTH    = 5,
   parameter int MD_LATENCY = 4
) (
   input logic                        clk_i,
   input logic                        rst_i,
   pipeline_stall_controller_if.slave bus
);

   if (MD_LATENCY < 2 || MD_LATENCY > 16) begin : g_bad_latency
      $error("MD_LATENCY must be in 2..16");
   end

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu_hazard;
   logic       md_hazard;
   logic       stall;
   logic       md_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Register 0 is hardwired, so a load to it never creates a dependency.
   always_comb begin
      lu_hazard = 1'b0;
      if (bus.EX_mem_read_i && (bus.EX_rd_i != '0)) begin
         lu_hazard = (bus.ID_rs_i == bus.EX_rd_i) ||
                     (bus.ID_uses_rt_i && (bus.ID_rt_i == bus.EX_rd_i));
      end
   end

   // The dependent instruction is released in the done cycle; HI/LO lands at its end.
   assign md_done   = (state == MD_WAIT) && (cnt == 4'd0);
   assign md_hazard = (state == MD_WAIT) && bus.ID_md_use_i && (cnt != 4'd0);
   assign stall     = lu_hazard | md_hazard;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (bus.EX_md_start_i) begin
               state_nxt = MD_WAIT;
               cnt_nxt   = CNT_INIT;
            end
         end
         MD_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Stall beats flush: a taken branch under stall is re-evaluated next cycle.
   always_comb begin
      bus.pc_write_o    = 1'b1;
      bus.IF_ID_write_o = 1'b1;
      bus.IF_ID_flush_o = bus.ID_branch_taken_i;
      bus.ID_EX_flush_o = 1'b0;
      bus.md_done_o     = md_done;
      if (rst_i) begin
         bus.pc_write_o    = 1'b0;
         bus.IF_ID_write_o = 1'b0;
         bus.IF_ID_flush_o = 1'b1;
         bus.ID_EX_flush_o = 1'b1;
         bus.md_done_o     = 1'b0;
      end else if (stall) begin
         bus.pc_write_o    = 1'b0;
         bus.IF_ID_write_o = 1'b0;
         bus.IF_ID_flush_o = 1'b0;
         bus.ID_EX_flush_o = 1'b1;
      end
   end

   assign bus.md_busy_o = (state == MD_WAIT);
   assign bus.state_dbg = state;

`ifdef STALL_COUNT_EN
   logic [31:0] stall_count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_count <= 32'd0;
      end else if (stall) begin
         stall_count <= stall_count + 32'd1;
      end
   end

   assign bus.stall_count_o = stall_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized + directed bench for pipeline_stall_controller against a timestamp-based reference model.
module tb_pipeline_stall_controller;

   localparam int RW = 5;
   localparam int L  = 4;
`ifdef STALL_COUNT_EN
   localparam int W = 39;
`else
   localparam int W = 7;
`endif

   logic clk;
   logic rst;

   pipeline_stall_controller_if #(.R_WIDTH(RW)) bus ();

   pipeline_stall_controller #(.R_WIDTH(RW), .MD_LATENCY(L)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state: absolute cycle timestamps
   int unsigned cyc;
   bit          md_active;
   int unsigned done_at;
   logic [31:0] m_count;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_pass;
   int           n_fail;

   function automatic bit model_stall();
      bit lu, mdh;
      lu  = bus.EX_mem_read_i && (bus.EX_rd_i != 0) &&
            ((bus.ID_rs_i == bus.EX_rd_i) || (bus.ID_uses_rt_i && (bus.ID_rt_i == bus.EX_rd_i)));
      mdh = md_active && bus.ID_md_use_i && (cyc != done_at);
      return lu || mdh;
   endfunction

   // Packed expectation: {count?, state_dbg, pc_write, if_id_write, if_id_flush, id_ex_flush, busy, done}
   function automatic logic [W-1:0] model_expect();
      logic [W-1:0] e;
      bit st;
      st = model_stall();
      e  = '0;
      if (rst) begin
         e[5:0] = {1'b0, 1'b0, 1'b1, 1'b1, md_active, 1'b0};
      end else begin
         e[5:0] = {!st, !st, (!st && bus.ID_branch_taken_i), st, md_active,
                   (md_active && (cyc == done_at))};
      end
      e[6] = md_active;
`ifdef STALL_COUNT_EN
      e[38:7] = m_count;
`endif
      return e;
   endfunction

   // Advance the model by the clock edge that just consumed the current inputs.
   task automatic model_edge();
      if (rst) begin
         md_active = 1'b0;
         m_count   = 32'd0;
      end else begin
         if (model_stall()) m_count = m_count + 32'd1;
         if (md_active) begin
            if (cyc == done_at) md_active = 1'b0;
         end else if (bus.EX_md_start_i) begin
            md_active = 1'b1;
            done_at   = cyc + L;
         end
      end
      cyc = cyc + 1;
   endtask

   // driver: one cycle of stimulus
   task automatic step(input logic r, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic uses_rt, input logic md_use, input logic br,
                       input logic [RW-1:0] rd, input logic mem_read, input logic md_start);
      @(posedge clk);
      model_edge();
      #1;
      rst                   = r;
      bus.ID_rs_i           = rs;
      bus.ID_rt_i           = rt;
      bus.ID_uses_rt_i      = uses_rt;
      bus.ID_md_use_i       = md_use;
      bus.ID_branch_taken_i = br;
      bus.EX_rd_i           = rd;
      bus.EX_mem_read_i     = mem_read;
      bus.EX_md_start_i     = md_start;
      exp_q.push_back(model_expect());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_step(input logic r);
      step(r, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         act = '0;
         act[6:0] = {bus.state_dbg, bus.pc_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
                     bus.ID_EX_flush_o, bus.md_busy_o, bus.md_done_o};
`ifdef STALL_COUNT_EN
         act[38:7] = bus.stall_count_o;
`endif
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: actual %h required %h", cyc, act, exp);
         end else begin
            n_pass++;
         end
      end
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      cyc       = 0;
      md_active = 1'b0;
      done_at   = 0;
      m_count   = 32'd0;
      rst                   = 1'b1;
      bus.ID_rs_i           = '0;
      bus.ID_rt_i           = '0;
      bus.ID_uses_rt_i      = 1'b0;
      bus.ID_md_use_i       = 1'b0;
      bus.ID_branch_taken_i = 1'b0;
      bus.EX_rd_i           = '0;
      bus.EX_mem_read_i     = 1'b0;
      bus.EX_md_start_i     = 1'b0;
      // first edge brings the DUT out of its unknown power-up state
      @(posedge clk);
      model_edge();

      // reset held with random inputs, then release to idle
      rand_step(1);
      rand_step(1);
      idle(2);

      // load-use on rs, rd=0 suppression, rt ignored when unused
      step(0, 8, 0, 0, 0, 0, 8, 1, 0);
      step(0, 8, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 8, 0, 0, 0, 8, 1, 0);
      step(0, 0, 8, 1, 0, 0, 8, 1, 0);
      idle(1);

      // MD sequence with the dependent instruction held in ID
      step(0, 0, 0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < L + 1; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 1);
      idle(2);

      // branch under load-use stall, then flush once the hazard clears
      step(0, 3, 0, 0, 0, 1, 3, 1, 0);
      step(0, 3, 0, 0, 0, 1, 3, 0, 0);
      idle(1);

      // reset mid-MD aborts it, then a fresh operation completes
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(L + 2);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) rand_step(1'($urandom_range(0, 49) == 0));
      idle(L + 2);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Hazard and sequencing controller for the 5-stage pipeline. It sits beside the forwarding logic in ID/EX.
- Detects load-use hazards that forwarding cannot cover and inserts bubbles.
- Sequences the multi-cycle multiply/divide unit (busy counter, HI/LO write strobe) and stalls dependent instructions.
- Generates IF/ID flush for taken branches; a stall always has priority over a flush.

Parameters:
- R_WIDTH, 5, register-index width (matches `R_WIDTH).
- MD_LATENCY, 4, multiply/divide unit cycles from start to result. Legal range 2..16.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ID_rs_i  input  R_WIDTH  rs index of the instruction in ID.
- ID_rt_i  input  R_WIDTH  rt index of the instruction in ID.
- ID_uses_rt_i  input  1  ID instruction reads rt as a source.
- ID_md_use_i  input  1  ID instruction is mfhi/mflo/mult/div (needs HI/LO or the MD unit).
- ID_branch_taken_i  input  1  branch resolved taken in ID.
- EX_rd_i  input  R_WIDTH  destination index of the instruction in EX.
- EX_mem_read_i  input  1  EX instruction is a load.
- EX_md_start_i  input  1  EX instruction is mult/div; MD unit starts this cycle.
- pc_write_o  output  1  PC update enable.
- IF_ID_write_o  output  1  IF/ID register enable.
- IF_ID_flush_o  output  1  zero the IF/ID register.
- ID_EX_flush_o  output  1  insert a bubble into ID/EX (zero its control bits).
- md_busy_o  output  1  MD unit in progress (registered).
- md_done_o  output  1  one-cycle HI/LO write strobe.
- stall_count_o  output  32  stall-cycle counter (only with STALL_COUNT_EN).

Behaviour:
- Registered state:
  - 2-state FSM: RUN, MD_WAIT.
  - 4-bit down-counter cnt.
- Reset (rst_i=1 at edge):
  - Next state RUN, cnt=0. md_busy_o=0 next cycle.
- Outputs forced while rst_i=1 (combinational override):
  - pc_write_o=0, IF_ID_write_o=0, IF_ID_flush_o=1, ID_EX_flush_o=1, md_done_o=0.
- Reset during MD_WAIT aborts the operation; md_done_o is never pulsed for it.
- lu_hazard (combinational):
  - Asserted when EX_mem_read_i=1, EX_rd_i!=0, and either ID_rs_i==EX_rd_i, or ID_uses_rt_i=1 and ID_rt_i==EX_rd_i.
  - Evaluated in both states.
- md_hazard (combinational):
  - Asserted when state==MD_WAIT, ID_md_use_i=1 and cnt!=0.
  - In the done cycle (cnt==0) the dependent instruction is released; HI/LO is written at the end of that cycle.
- stall = lu_hazard | md_hazard.
- Output rules when stall=1:
  - pc_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, IF_ID_flush_o=0.
  - A coincident taken branch is suppressed and re-evaluated next cycle.
- Output rules when stall=0:
  - pc_write_o=1, IF_ID_write_o=1, ID_EX_flush_o=0, IF_ID_flush_o=ID_branch_taken_i.
- Load-use latency: exactly one bubble per hazard. The next cycle the load is in MEM and forwarding handles it.
- FSM transitions:
  - RUN + EX_md_start_i=1 -> MD_WAIT, cnt<=MD_LATENCY-1.
  - RUN + EX_md_start_i=0 -> RUN.
  - MD_WAIT with cnt!=0 -> cnt<=cnt-1, stay in MD_WAIT.
  - MD_WAIT with cnt==0 -> md_done_o=1 this cycle, next state RUN.
- md_busy_o = (state==MD_WAIT), registered.
- md_done_o = (state==MD_WAIT && cnt==0), combinational from registered state.
- Result timing: with no reset, md_done_o goes high exactly MD_LATENCY cycles after the cycle in which EX_md_start_i was sampled.
- EX_md_start_i in MD_WAIT is ignored. The decoder guarantees this cannot occur, because md_hazard stalls any mult/div in ID.
- Back-to-back operations: EX_md_start_i in the same cycle as md_done_o is also in MD_WAIT and is ignored. A new mult/div reaches EX no earlier than the following cycle, in RUN.

Optional Feature:
- Macro: STALL_COUNT_EN.
- With STALL_COUNT_EN defined:
  - Port stall_count_o exists: 32-bit register, reset to 0.
  - Increments by 1 on every clock edge with rst_i=0 and stall=1.
  - Wraps 0xFFFFFFFF -> 0.
- Without STALL_COUNT_EN:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random inputs -> pc_write_o=0, both flushes=1, md_busy_o=0. After release with idle inputs -> pc_write_o=1, IF_ID_write_o=1.
- Load-use on rs: EX_mem_read_i=1, EX_rd_i=8, ID_rs_i=8 for 1 cycle -> pc_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1. Repeat with EX_rd_i=0 -> no stall. Repeat with ID_rt_i=8 and ID_uses_rt_i=0 -> no stall.
- MD sequence, MD_LATENCY=4: EX_md_start_i=1 at cycle 0 -> md_busy_o=1 in cycles 1-4, md_done_o=1 only in cycle 4. With ID_md_use_i held 1, stall in cycles 1-3 and released in cycle 4.
- Priority: ID_branch_taken_i=1 together with lu_hazard -> IF_ID_flush_o=0, ID_EX_flush_o=1. Next cycle, hazard gone -> IF_ID_flush_o=1.
- Reset mid-MD: rst_i=1 at cycle 2 of an MD operation -> md_done_o never pulses. State is RUN after reset; a new EX_md_start_i gives md_done_o 4 cycles later.
- STALL_COUNT_EN build: one load-use stall plus 3 md stalls -> stall_count_o=4. Preload near wrap and force a stall -> stall_count_o goes 0xFFFFFFFF -> 0.
